// File: rtl/dmem_responder.sv
`timescale 1ns / 1ps
// dmem_responder: data-memory responder sitting behind the core's load/store path.
// Accepts one load or store at a time while idle, waits a fixed number of cycles,
// then performs the access on an internal word array and pulses a one-cycle response.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   mem_read   load request
//   mem_write  store request
//   addr       byte address (upper bits above the array size are ignored)
//   wdata      store data, right-aligned
//   funct3     RV32I access size/sign encoding
//   req_ready  idle; a request presented now is accepted at this edge
//   busy       request in flight (wait-state cycles)
//   rsp_valid  one-cycle response strobe
//   rdata      extended load data; 0 for stores and errors
//   err        access rejected (misaligned, illegal funct3, or read+write together)
//
// LATENCY must be in 1..15 (4-bit wait counter).
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [2:0]            funct3,
    output logic                  req_ready,
    output logic                  busy,
    output logic                  rsp_valid,
    output logic [31:0]           rdata,
    output logic                  err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LOW_W = IDX_W + 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [LOW_W-1:0] addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       funct3_q;
    logic             is_load_q;
    logic             err_q;

    logic             accept;
    logic             req_err;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic [3:0]       be;
    logic [31:0]      wd_lanes;
    logic             do_write;

    logic [31:0] mem [DEPTH_WORDS];

    // Address bits above the array span alias onto it.
    if (ADDR_WIDTH > LOW_W) begin : gen_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[ADDR_WIDTH-1:LOW_W];
    end

    assign accept = (state_q == StIdle) && (mem_read || mem_write);

    // Error decode on the incoming request; the verdict is latched with it.
    always_comb begin
        req_err = 1'b0;
        if (mem_read && mem_write) begin
            req_err = 1'b1;
        end else if (mem_read) begin
            case (funct3)
                3'b000, 3'b100: req_err = 1'b0;
                3'b001, 3'b101: req_err = addr[0];
                3'b010:         req_err = |addr[1:0];
                default:        req_err = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000:  req_err = 1'b0;
                3'b001:  req_err = addr[0];
                3'b010:  req_err = |addr[1:0];
                default: req_err = 1'b1;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            addr_q    <= addr[LOW_W-1:0];
            wdata_q   <= wdata;
            funct3_q  <= funct3;
            is_load_q <= mem_read;
            err_q     <= req_err;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                // <= guards against a corrupted counter stalling forever
                if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load path: lane select and extension from the addressed word
    assign word_idx = addr_q[LOW_W-1:2];
    assign word     = mem[word_idx];
    assign byte_sel = 8'(word >> {addr_q[1:0], 3'b000});
    assign half_sel = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = '0;
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = word;
            3'b100:  load_data = {24'b0, byte_sel};
            3'b101:  load_data = {16'b0, half_sel};
            default: load_data = '0;
        endcase
    end

    // Store path: replicate data across lanes, byte enables pick the target
    always_comb begin
        be       = 4'b0000;
        wd_lanes = wdata_q;
        case (funct3_q)
            3'b000: begin
                be       = 4'b0001 << addr_q[1:0];
                wd_lanes = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                be       = 4'b1111;
                wd_lanes = wdata_q;
            end
            default: begin
                be       = 4'b0000;
                wd_lanes = wdata_q;
            end
        endcase
    end

    // Write commits at the edge closing the response cycle; reset aborts it.
    assign do_write = (state_q == StResp) && !is_load_q && !err_q && !rst;

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wd_lanes[8*b +: 8];
                end
            end
        end
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == StIdle) && !rst;
        busy      = (state_q == StWait);
        rsp_valid = (state_q == StResp);
        err       = (state_q == StResp) && err_q;
        rdata     = ((state_q == StResp) && is_load_q && !err_q) ? load_data : 32'h0;
    end

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns / 1ps
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) share one stimulus
// stream; each request is issued only when all three are idle, so all accept at the
// same edge. Expected responses come from a byte-addressed memory model.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;

    logic        rr [3];
    logic        bsy[3];
    logic        rv [3];
    logic [31:0] rd [3];
    logic        er [3];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t       sbq[3][$];
    logic [7:0] mm [0:1023];
    int         cyc;
    int         checks;
    int         errors;

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .wdata(wdata), .funct3(funct3), .req_ready(rr[0]), .busy(bsy[0]),
        .rsp_valid(rv[0]), .rdata(rd[0]), .err(er[0])
    );

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .wdata(wdata), .funct3(funct3), .req_ready(rr[1]), .busy(bsy[1]),
        .rsp_valid(rv[1]), .rdata(rd[1]), .err(er[1])
    );

    dmem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
        .wdata(wdata), .funct3(funct3), .req_ready(rr[2]), .busy(bsy[2]),
        .rsp_valid(rv[2]), .rdata(rd[2]), .err(er[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference: little-endian byte memory, size/sign from funct3, natural alignment.
    task automatic model(input logic rdq, input logic wrq, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, input bit commit,
                         output logic [31:0] exp_rd, output logic exp_err);
        int          base;
        int          sz;
        bit          sgn;
        bit          bad;
        logic [31:0] v;
        base = int'(a[9:0]);
        sz   = 1;
        sgn  = 1'b0;
        bad  = 1'b0;
        v    = '0;
        if (rdq && wrq) begin
            bad = 1'b1;
        end else if (rdq) begin
            case (f3)
                3'b000:  begin sz = 1; sgn = 1'b1; end
                3'b001:  begin sz = 2; sgn = 1'b1; end
                3'b010:  sz = 4;
                3'b100:  sz = 1;
                3'b101:  sz = 2;
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                3'b000:  sz = 1;
                3'b001:  sz = 2;
                3'b010:  sz = 4;
                default: bad = 1'b1;
            endcase
        end
        if (!bad && (base % sz) != 0) bad = 1'b1;
        exp_err = bad;
        exp_rd  = '0;
        if (!bad && rdq) begin
            for (int b = 0; b < sz; b++) v = v | (32'(mm[base + b]) << (8 * b));
            if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
            exp_rd = v;
        end
        if (!bad && wrq && commit) begin
            for (int b = 0; b < sz; b++) mm[base + b] = wd[8*b +: 8];
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < 3; i++) sbq[i].delete();
    endtask

    // Returns at a falling edge with every instance idle and no response pending.
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 &&
                     rr[0] && rr[1] && rr[2]) && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout @cycle %0d: got ready %0b%0b%0b expected 111",
                     cyc, rr[0], rr[1], rr[2]);
            flush_all();
        end
    endtask

    task automatic issue(input logic rdq, input logic wrq, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, input bit abort);
        exp_t e;
        wait_idle();
        mem_read  = rdq;
        mem_write = wrq;
        addr      = a;
        wdata     = wd;
        funct3    = f3;
        model(rdq, wrq, a, wd, f3, !abort, e.rdata, e.err);
        e.acc = cyc;
        for (int i = 0; i < 3; i++) sbq[i].push_back(e);
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = $urandom;
        wdata     = $urandom;
        funct3    = 3'($urandom);
        if (abort) begin
            rst = 1'b1;
            flush_all();
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    // Monitor: per instance, check handshake flags every cycle and pop on rsp_valid.
    always begin
        exp_t e;
        int   due;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                check($sformatf("ready_in_rst[L%0d]", lat(i)), {31'b0, rr[i]}, 32'd0);
            end else if (sbq[i].size() == 0) begin
                check($sformatf("idle_flags{rdy,busy,vld,err}[L%0d]", lat(i)),
                      {28'b0, rr[i], bsy[i], rv[i], er[i]}, 32'h8);
                check($sformatf("idle_rdata[L%0d]", lat(i)), rd[i], 32'h0);
            end else begin
                e   = sbq[i][0];
                due = e.acc + lat(i);
                if (cyc > due) begin
                    check($sformatf("rsp_timeout[L%0d]", lat(i)), {31'b0, rv[i]}, 32'd1);
                    void'(sbq[i].pop_front());
                end else begin
                    check($sformatf("flags{rdy,busy,vld}[L%0d]", lat(i)),
                          {29'b0, rr[i], bsy[i], rv[i]},
                          {29'b0, 1'b0, (cyc < due), (cyc == due)});
                    if (rv[i]) begin
                        check($sformatf("rdata[L%0d]", lat(i)), rd[i], e.rdata);
                        check($sformatf("err[L%0d]", lat(i)), {31'b0, er[i]}, {31'b0, e.err});
                        void'(sbq[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic        rdq;
        logic        wrq;
        logic [31:0] a;
        logic [2:0]  f3;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        funct3    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Give the exercised region (words 0..15) known contents.
        for (int w = 0; w < 16; w++) issue(1'b0, 1'b1, 32'(4 * w), $urandom, 3'b010, 1'b0);

        issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0);   // SW
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);           // LW
        issue(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, 1'b0);           // LB
        issue(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, 1'b0);           // LBU
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b001, 1'b0);           // LH
        issue(1'b1, 1'b0, 32'h12, 32'h0, 3'b101, 1'b0);           // LHU
        issue(1'b0, 1'b1, 32'h11, 32'h0000_00AA, 3'b000, 1'b0);   // SB
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);           // LW
        issue(1'b1, 1'b0, 32'h12, 32'h0, 3'b010, 1'b0);           // misaligned LW
        issue(1'b0, 1'b1, 32'h21, 32'h1234_5678, 3'b001, 1'b0);   // misaligned SH
        issue(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
        issue(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 3'b010, 1'b0);   // read+write together
        issue(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0);
        issue(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 1'b0);          // aliases word 0
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b0);           // illegal load funct3
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b110, 1'b0);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b111, 1'b0);
        issue(1'b0, 1'b1, 32'h10, 32'h0, 3'b100, 1'b0);           // illegal store funct3
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0);
        issue(1'b0, 1'b1, 32'h30, 32'h5555_AAAA, 3'b010, 1'b1);   // SW aborted by reset
        issue(1'b1, 1'b0, 32'h30, 32'h0, 3'b010, 1'b0);

        for (int n = 0; n < 300; n++) begin
            rdq = 1'($urandom_range(0, 1));
            wrq = !rdq;
            if ($urandom_range(0, 15) == 0) begin
                rdq = 1'b1;
                wrq = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else if (wrq) begin
                f3 = 3'($urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'b000;
                    1:       f3 = 3'b001;
                    2:       f3 = 3'b010;
                    3:       f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            a = $urandom;
            a[9:6] = 4'b0000;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            issue(rdq, wrq, a, $urandom, f3, ($urandom_range(0, 39) == 0));
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
